// File: rtl/pcie_tx_arbiter.sv
// -----------------------------------------------------------------------------
// pcie_tx_arbiter
//
// Shares the PCIe core transmit AXI-Stream interface between two TLP sources:
// requester 0 (completion engine) and requester 1 (DMA write engine).
// Ownership is granted per packet, and the data path is a combinational
// passthrough from the owning source to the core.
//
// Ports
//   user_clk, user_reset            clock; synchronous active-high reset
//   s0_t*  / s0_tready              requester 0 AXI-Stream slave
//   s1_t*  / s1_tready              requester 1 AXI-Stream slave
//   m_axis_tx_t* / m_axis_tx_tready AXI-Stream master to the core
//   tx_buf_av                       core transmit buffers available
//   grant                           one-hot owner (bit0 = port 0), 00 when idle
//   pkt_cnt0 / pkt_cnt1             completed packets per port (wrapping)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate between eligible requesters
// SEND0 | requester 0 owns the core interface until its tlast beat
// SEND1 | requester 1 owns the core interface until its tlast beat
// -----------------------------------------------------------------------------
module pcie_tx_arbiter #(
  parameter int DATA_W     = 64,
  parameter int MIN_BUF    = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  user_clk,
  input  logic                  user_reset,

  input  logic [DATA_W-1:0]     s0_tdata,
  input  logic [DATA_W/8-1:0]   s0_tkeep,
  input  logic                  s0_tlast,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,

  input  logic [DATA_W-1:0]     s1_tdata,
  input  logic [DATA_W/8-1:0]   s1_tkeep,
  input  logic                  s1_tlast,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,

  output logic [DATA_W-1:0]     m_axis_tx_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tx_tkeep,
  output logic                  m_axis_tx_tlast,
  output logic                  m_axis_tx_tvalid,
  input  logic                  m_axis_tx_tready,

  input  logic [5:0]            tx_buf_av,
  output logic [1:0]            grant,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  localparam logic [5:0] C_MIN_BUF = 6'(MIN_BUF);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;   // 0: port 0 granted last, 1: port 1 granted last
  logic [15:0] r_pkt_cnt0;
  logic [15:0] r_pkt_cnt1;

  logic        w_buf_ok;
  logic        w_elig0;
  logic        w_elig1;
  logic        w_pick1;
  logic        w_done0;
  logic        w_done1;

  // Buffer credit only matters for the decision to start a packet; once a
  // packet is owned it runs to tlast whatever tx_buf_av does.
  assign w_buf_ok = (tx_buf_av >= C_MIN_BUF);
  assign w_elig0  = s0_tvalid & w_buf_ok;
  assign w_elig1  = s1_tvalid & w_buf_ok;

  // Port 1 wins when it is the only eligible port, or on a round-robin tie
  // where port 0 was granted last.
  always_comb begin
    w_pick1 = 1'b0;
    if (w_elig1 && !w_elig0) begin
      w_pick1 = 1'b1;
    end else if (w_elig0 && w_elig1 && (FIXED_PRIO == 0) && !r_last_grant) begin
      w_pick1 = 1'b1;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    m_axis_tx_tdata  = '0;
    m_axis_tx_tkeep  = '0;
    m_axis_tx_tlast  = 1'b0;
    m_axis_tx_tvalid = 1'b0;
    s0_tready        = 1'b0;
    s1_tready        = 1'b0;
    w_done0          = 1'b0;
    w_done1          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_elig0 || w_elig1) begin
          w_next_state = w_pick1 ? SEND1 : SEND0;
        end
      end
      SEND0: begin
        m_axis_tx_tdata  = s0_tdata;
        m_axis_tx_tkeep  = s0_tkeep;
        m_axis_tx_tlast  = s0_tlast;
        m_axis_tx_tvalid = s0_tvalid;
        s0_tready        = m_axis_tx_tready;
        w_done0          = s0_tvalid & m_axis_tx_tready & s0_tlast;
        if (w_done0) begin
          w_next_state = IDLE;
        end
      end
      SEND1: begin
        m_axis_tx_tdata  = s1_tdata;
        m_axis_tx_tkeep  = s1_tkeep;
        m_axis_tx_tlast  = s1_tlast;
        m_axis_tx_tvalid = s1_tvalid;
        s1_tready        = m_axis_tx_tready;
        w_done1          = s1_tvalid & m_axis_tx_tready & s1_tlast;
        if (w_done1) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;     // port 0 wins the first tie after reset
      r_pkt_cnt0   <= '0;
      r_pkt_cnt1   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_next_state == SEND0) begin
        r_last_grant <= 1'b0;
      end else if (r_state == IDLE && w_next_state == SEND1) begin
        r_last_grant <= 1'b1;
      end
      if (w_done0) begin
        r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
      end
      if (w_done1) begin
        r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
      end
    end
  end

  assign grant    = {r_state == SEND1, r_state == SEND0};
  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pcie_tx_arbiter
//
// Directed bench for pcie_tx_arbiter. Two instances are built: u_rr with
// round-robin arbitration and u_fp with fixed priority; each has its own
// stimulus set, indexed [0] and [1] respectively.
// Inputs change 1 ns after the rising edge, outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_pcie_tx_arbiter;

  localparam int DW = 64;
  localparam int KW = DW / 8;

  logic          user_clk = 1'b0;
  logic          user_reset;

  logic [DW-1:0] s0_tdata   [2];
  logic [KW-1:0] s0_tkeep   [2];
  logic          s0_tlast   [2];
  logic          s0_tvalid  [2];
  logic          s0_tready  [2];
  logic [DW-1:0] s1_tdata   [2];
  logic [KW-1:0] s1_tkeep   [2];
  logic          s1_tlast   [2];
  logic          s1_tvalid  [2];
  logic          s1_tready  [2];
  logic [DW-1:0] m_tdata    [2];
  logic [KW-1:0] m_tkeep    [2];
  logic          m_tlast    [2];
  logic          m_tvalid   [2];
  logic          m_tready   [2];
  logic [5:0]    tx_buf_av  [2];
  logic [1:0]    grant      [2];
  logic [15:0]   pkt_cnt0   [2];
  logic [15:0]   pkt_cnt1   [2];

  int checks = 0;
  int errors = 0;

  logic [1:0]    cap_grant [8];
  int            cap_ng;
  logic [DW-1:0] cap_data  [16];
  int            cap_nd;
  int            done_pkts;

  always #5 user_clk = ~user_clk;

  pcie_tx_arbiter #(.DATA_W(DW), .MIN_BUF(2), .FIXED_PRIO(0)) u_rr (
    .user_clk(user_clk), .user_reset(user_reset),
    .s0_tdata(s0_tdata[0]), .s0_tkeep(s0_tkeep[0]), .s0_tlast(s0_tlast[0]),
    .s0_tvalid(s0_tvalid[0]), .s0_tready(s0_tready[0]),
    .s1_tdata(s1_tdata[0]), .s1_tkeep(s1_tkeep[0]), .s1_tlast(s1_tlast[0]),
    .s1_tvalid(s1_tvalid[0]), .s1_tready(s1_tready[0]),
    .m_axis_tx_tdata(m_tdata[0]), .m_axis_tx_tkeep(m_tkeep[0]),
    .m_axis_tx_tlast(m_tlast[0]), .m_axis_tx_tvalid(m_tvalid[0]),
    .m_axis_tx_tready(m_tready[0]), .tx_buf_av(tx_buf_av[0]),
    .grant(grant[0]), .pkt_cnt0(pkt_cnt0[0]), .pkt_cnt1(pkt_cnt1[0])
  );

  pcie_tx_arbiter #(.DATA_W(DW), .MIN_BUF(2), .FIXED_PRIO(1)) u_fp (
    .user_clk(user_clk), .user_reset(user_reset),
    .s0_tdata(s0_tdata[1]), .s0_tkeep(s0_tkeep[1]), .s0_tlast(s0_tlast[1]),
    .s0_tvalid(s0_tvalid[1]), .s0_tready(s0_tready[1]),
    .s1_tdata(s1_tdata[1]), .s1_tkeep(s1_tkeep[1]), .s1_tlast(s1_tlast[1]),
    .s1_tvalid(s1_tvalid[1]), .s1_tready(s1_tready[1]),
    .m_axis_tx_tdata(m_tdata[1]), .m_axis_tx_tkeep(m_tkeep[1]),
    .m_axis_tx_tlast(m_tlast[1]), .m_axis_tx_tvalid(m_tvalid[1]),
    .m_axis_tx_tready(m_tready[1]), .tx_buf_av(tx_buf_av[1]),
    .grant(grant[1]), .pkt_cnt0(pkt_cnt0[1]), .pkt_cnt1(pkt_cnt1[1])
  );

  function automatic logic [DW-1:0] mk(input int p, input int k, input int b);
    return (64'(p) << 16) | (64'(k) << 8) | 64'(b);
  endfunction

  task automatic cyc();
    @(posedge user_clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      s0_tdata[d] = '0; s0_tkeep[d] = '0; s0_tlast[d] = 1'b0; s0_tvalid[d] = 1'b0;
      s1_tdata[d] = '0; s1_tkeep[d] = '0; s1_tlast[d] = 1'b0; s1_tvalid[d] = 1'b0;
      m_tready[d] = 1'b0; tx_buf_av[d] = 6'd0;
    end
  endtask

  task automatic apply_reset();
    user_reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    user_reset = 1'b0;
  endtask

  // Both requesters of instance d send 3-beat packets back to back until four
  // packets have left the master port; grants and forwarded data are captured.
  task automatic run_continuous(input int d);
    int bt0, bt1, pk0, pk1;
    logic [1:0] prev;
    logic x0, x1;
    bt0 = 0; bt1 = 0; pk0 = 0; pk1 = 0; prev = 2'b00;
    cap_ng = 0; cap_nd = 0; done_pkts = 0;
    tx_buf_av[d] = 6'd10;
    m_tready[d]  = 1'b1;
    for (int c = 0; c < 60 && done_pkts < 4; c++) begin
      s0_tvalid[d] = 1'b1; s0_tkeep[d] = 8'hFF;
      s0_tdata[d]  = mk(0, pk0, bt0); s0_tlast[d] = (bt0 == 2);
      s1_tvalid[d] = 1'b1; s1_tkeep[d] = 8'hFF;
      s1_tdata[d]  = mk(1, pk1, bt1); s1_tlast[d] = (bt1 == 2);
      #1;
      if (grant[d] != 2'b00 && prev == 2'b00 && cap_ng < 8) begin
        cap_grant[cap_ng] = grant[d];
        cap_ng++;
      end
      prev = grant[d];
      if (m_tvalid[d] && m_tready[d]) begin
        if (cap_nd < 16) begin
          cap_data[cap_nd] = m_tdata[d];
          cap_nd++;
        end
        if (m_tlast[d]) done_pkts++;
      end
      x0 = s0_tvalid[d] & s0_tready[d];
      x1 = s1_tvalid[d] & s1_tready[d];
      cyc();
      if (x0) begin if (bt0 == 2) begin bt0 = 0; pk0++; end else bt0++; end
      if (x1) begin if (bt1 == 2) begin bt1 = 0; pk1++; end else bt1++; end
    end
    s0_tvalid[d] = 1'b0;
    s1_tvalid[d] = 1'b0;
  endtask

  task automatic test_reset();
    user_reset = 1'b1;
    idle_inputs();
    s0_tvalid[0] = 1'b1; s1_tvalid[0] = 1'b1; s0_tdata[0] = 64'h1234;
    tx_buf_av[0] = 6'd10; m_tready[0] = 1'b1;
    cyc();
    cyc();
    checks++; if (grant[0] !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b exp 00", grant[0]); end
    checks++; if (s0_tready[0] !== 1'b0 || s1_tready[0] !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b%b exp 00", s1_tready[0], s0_tready[0]); end
    checks++; if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b exp 0", m_tvalid[0]); end
    checks++; if (m_tdata[0] !== 64'h0) begin errors++; $display("FAIL rst_tdata: got %h exp 0", m_tdata[0]); end
    checks++; if (pkt_cnt0[0] !== 16'h0 || pkt_cnt1[0] !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h/%h exp 0/0", pkt_cnt0[0], pkt_cnt1[0]); end
    user_reset = 1'b0;
  endtask

  task automatic test_first_tie();
    apply_reset();
    s0_tdata[0] = 64'hA0; s0_tkeep[0] = 8'hFF; s0_tlast[0] = 1'b0; s0_tvalid[0] = 1'b1;
    s1_tdata[0] = 64'hB0; s1_tkeep[0] = 8'hFF; s1_tlast[0] = 1'b1; s1_tvalid[0] = 1'b1;
    tx_buf_av[0] = 6'd10; m_tready[0] = 1'b1;
    #1;
    checks++; if (grant[0] !== 2'b00) begin errors++; $display("FAIL tie_pre_grant: got %b exp 00", grant[0]); end
    checks++; if (m_tvalid[0] !== 1'b0 || m_tdata[0] !== 64'h0) begin errors++; $display("FAIL tie_idle_out: got v=%b d=%h exp v=0 d=0", m_tvalid[0], m_tdata[0]); end
    cyc();
    checks++; if (grant[0] !== 2'b01) begin errors++; $display("FAIL tie_grant0: got %b exp 01", grant[0]); end
    checks++; if (m_tdata[0] !== 64'hA0) begin errors++; $display("FAIL tie_data0: got %h exp a0", m_tdata[0]); end
    checks++; if (s0_tready[0] !== 1'b1 || s1_tready[0] !== 1'b0) begin errors++; $display("FAIL tie_tready: got s0=%b s1=%b exp 1/0", s0_tready[0], s1_tready[0]); end
    cyc();
    s0_tdata[0] = 64'hA1; s0_tlast[0] = 1'b1;
    #1;
    checks++; if (m_tdata[0] !== 64'hA1 || m_tlast[0] !== 1'b1) begin errors++; $display("FAIL tie_data1: got %h last=%b exp a1 last=1", m_tdata[0], m_tlast[0]); end
    cyc();
    s0_tvalid[0] = 1'b0;
    checks++; if (grant[0] !== 2'b00) begin errors++; $display("FAIL tie_gap: got %b exp 00", grant[0]); end
    checks++; if (pkt_cnt0[0] !== 16'd1) begin errors++; $display("FAIL tie_cnt0: got %0d exp 1", pkt_cnt0[0]); end
    cyc();
    checks++; if (grant[0] !== 2'b10) begin errors++; $display("FAIL tie_grant1: got %b exp 10", grant[0]); end
    checks++; if (m_tdata[0] !== 64'hB0) begin errors++; $display("FAIL tie_data_b: got %h exp b0", m_tdata[0]); end
    cyc();
    s1_tvalid[0] = 1'b0;
    checks++; if (grant[0] !== 2'b00 || pkt_cnt1[0] !== 16'd1) begin errors++; $display("FAIL tie_end: got g=%b c1=%0d exp 00/1", grant[0], pkt_cnt1[0]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    apply_reset();
    run_continuous(0);
    checks++; if (done_pkts !== 4) begin errors++; $display("FAIL rr_budget: got %0d pkts exp 4", done_pkts); end
    checks++; if (cap_ng !== 4) begin errors++; $display("FAIL rr_ngrants: got %0d exp 4", cap_ng); end
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (cap_grant[k] !== eg) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", k, cap_grant[k], eg); end
    end
    checks++; if (cap_nd !== 12) begin errors++; $display("FAIL rr_nbeats: got %0d exp 12", cap_nd); end
    for (int i = 0; i < 12 && i < cap_nd; i++) begin
      checks++; if (cap_data[i] !== mk((i / 3) % 2, i / 6, i % 3)) begin errors++; $display("FAIL rr_data%0d: got %h exp %h", i, cap_data[i], mk((i / 3) % 2, i / 6, i % 3)); end
    end
    checks++; if (pkt_cnt0[0] !== 16'd2 || pkt_cnt1[0] !== 16'd2) begin errors++; $display("FAIL rr_cnt: got %0d/%0d exp 2/2", pkt_cnt0[0], pkt_cnt1[0]); end
  endtask

  task automatic test_fixed_prio();
    apply_reset();
    run_continuous(1);
    checks++; if (done_pkts !== 4) begin errors++; $display("FAIL fp_budget: got %0d pkts exp 4", done_pkts); end
    checks++; if (cap_ng !== 4) begin errors++; $display("FAIL fp_ngrants: got %0d exp 4", cap_ng); end
    for (int k = 0; k < 4 && k < cap_ng; k++) begin
      checks++; if (cap_grant[k] !== 2'b01) begin errors++; $display("FAIL fp_grant%0d: got %b exp 01", k, cap_grant[k]); end
    end
    for (int i = 0; i < 12 && i < cap_nd; i++) begin
      checks++; if (cap_data[i] !== mk(0, i / 3, i % 3)) begin errors++; $display("FAIL fp_data%0d: got %h exp %h", i, cap_data[i], mk(0, i / 3, i % 3)); end
    end
    checks++; if (pkt_cnt0[1] !== 16'd4 || pkt_cnt1[1] !== 16'd0) begin errors++; $display("FAIL fp_cnt: got %0d/%0d exp 4/0", pkt_cnt0[1], pkt_cnt1[1]); end
  endtask

  task automatic test_buf_threshold();
    apply_reset();
    s1_tdata[0] = 64'hC0; s1_tkeep[0] = 8'hFF; s1_tlast[0] = 1'b0; s1_tvalid[0] = 1'b1;
    tx_buf_av[0] = 6'd1; m_tready[0] = 1'b1;
    cyc();
    cyc();
    checks++; if (grant[0] !== 2'b00 || s1_tready[0] !== 1'b0) begin errors++; $display("FAIL buf_below: got g=%b rdy=%b exp 00/0", grant[0], s1_tready[0]); end
    tx_buf_av[0] = 6'd2;
    cyc();
    checks++; if (grant[0] !== 2'b10 || s1_tready[0] !== 1'b1) begin errors++; $display("FAIL buf_at_min: got g=%b rdy=%b exp 10/1", grant[0], s1_tready[0]); end
    tx_buf_av[0] = 6'd0;
    cyc();
    s1_tdata[0] = 64'hC1; s1_tvalid[0] = 1'b0;
    #1;
    checks++; if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL buf_gap_valid: got %b exp 0", m_tvalid[0]); end
    cyc();
    checks++; if (grant[0] !== 2'b10) begin errors++; $display("FAIL buf_hold: got %b exp 10", grant[0]); end
    s1_tvalid[0] = 1'b1;
    #1;
    checks++; if (m_tdata[0] !== 64'hC1 || m_tvalid[0] !== 1'b1) begin errors++; $display("FAIL buf_data1: got %h v=%b exp c1 v=1", m_tdata[0], m_tvalid[0]); end
    cyc();
    s1_tdata[0] = 64'hC2; s1_tlast[0] = 1'b1;
    cyc();
    s1_tvalid[0] = 1'b0;
    checks++; if (grant[0] !== 2'b00 || pkt_cnt1[0] !== 16'd1 || pkt_cnt0[0] !== 16'd0) begin errors++; $display("FAIL buf_done: got g=%b c0=%0d c1=%0d exp 00/0/1", grant[0], pkt_cnt0[0], pkt_cnt1[0]); end
  endtask

  task automatic test_tready_toggle();
    int bt, nf;
    logic x0, last_done;
    apply_reset();
    s0_tvalid[0] = 1'b1; s0_tdata[0] = 64'hD0; s0_tkeep[0] = 8'hFF;
    s1_tvalid[0] = 1'b1; s1_tdata[0] = 64'hE0; s1_tkeep[0] = 8'hFF; s1_tlast[0] = 1'b1;
    tx_buf_av[0] = 6'd10; m_tready[0] = 1'b0;
    cyc();
    checks++; if (grant[0] !== 2'b01) begin errors++; $display("FAIL tog_grant: got %b exp 01", grant[0]); end
    bt = 0; nf = 0; last_done = 1'b0;
    for (int c = 0; c < 20 && !last_done; c++) begin
      m_tready[0]  = (c % 2 == 0);
      s0_tdata[0]  = 64'hD0 + 64'(bt);
      s0_tkeep[0]  = (bt == 3) ? 8'h0F : 8'hFF;
      s0_tlast[0]  = (bt == 3);
      #1;
      checks++; if (s0_tready[0] !== m_tready[0]) begin errors++; $display("FAIL tog_s0rdy c%0d: got %b exp %b", c, s0_tready[0], m_tready[0]); end
      checks++; if (s1_tready[0] !== 1'b0) begin errors++; $display("FAIL tog_s1rdy c%0d: got %b exp 0", c, s1_tready[0]); end
      if (m_tvalid[0] && m_tready[0]) begin
        checks++; if (m_tdata[0] !== 64'hD0 + 64'(nf)) begin errors++; $display("FAIL tog_data%0d: got %h exp %h", nf, m_tdata[0], 64'hD0 + 64'(nf)); end
        checks++; if (m_tkeep[0] !== ((nf == 3) ? 8'h0F : 8'hFF)) begin errors++; $display("FAIL tog_keep%0d: got %h", nf, m_tkeep[0]); end
        nf++;
        if (m_tlast[0]) last_done = 1'b1;
      end
      x0 = s0_tvalid[0] & s0_tready[0];
      cyc();
      if (x0) bt++;
    end
    s0_tvalid[0] = 1'b0;
    checks++; if (nf !== 4) begin errors++; $display("FAIL tog_beats: got %0d exp 4", nf); end
    checks++; if (grant[0] !== 2'b00 || pkt_cnt0[0] !== 16'd1) begin errors++; $display("FAIL tog_end: got g=%b c0=%0d exp 00/1", grant[0], pkt_cnt0[0]); end
    m_tready[0] = 1'b1;
    cyc();
    checks++; if (grant[0] !== 2'b10) begin errors++; $display("FAIL tog_next: got %b exp 10", grant[0]); end
    s1_tvalid[0] = 1'b0;
  endtask

  task automatic test_single_beat();
    apply_reset();
    s0_tvalid[0] = 1'b1; s0_tdata[0] = 64'hE0; s0_tkeep[0] = 8'hFF; s0_tlast[0] = 1'b1;
    tx_buf_av[0] = 6'd10; m_tready[0] = 1'b1;
    cyc();
    checks++; if (grant[0] !== 2'b01 || m_tlast[0] !== 1'b1 || m_tdata[0] !== 64'hE0) begin errors++; $display("FAIL sb_first: got g=%b l=%b d=%h exp 01/1/e0", grant[0], m_tlast[0], m_tdata[0]); end
    cyc();
    s0_tdata[0] = 64'hE1;
    checks++; if (grant[0] !== 2'b00 || pkt_cnt0[0] !== 16'd1 || s0_tready[0] !== 1'b0) begin errors++; $display("FAIL sb_idle: got g=%b c0=%0d rdy=%b exp 00/1/0", grant[0], pkt_cnt0[0], s0_tready[0]); end
    cyc();
    checks++; if (grant[0] !== 2'b01 || m_tdata[0] !== 64'hE1) begin errors++; $display("FAIL sb_second: got g=%b d=%h exp 01/e1", grant[0], m_tdata[0]); end
    cyc();
    s0_tvalid[0] = 1'b0;
    checks++; if (grant[0] !== 2'b00 || pkt_cnt0[0] !== 16'd2) begin errors++; $display("FAIL sb_end: got g=%b c0=%0d exp 00/2", grant[0], pkt_cnt0[0]); end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    force u_rr.r_pkt_cnt0 = 16'hFFFE;
    #1;
    release u_rr.r_pkt_cnt0;
    s0_tvalid[0] = 1'b1; s0_tdata[0] = 64'hF0; s0_tkeep[0] = 8'hFF; s0_tlast[0] = 1'b1;
    tx_buf_av[0] = 6'd10; m_tready[0] = 1'b1;
    cyc(); cyc();
    checks++; if (pkt_cnt0[0] !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h exp ffff", pkt_cnt0[0]); end
    cyc(); cyc();
    checks++; if (pkt_cnt0[0] !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h exp 0000", pkt_cnt0[0]); end
    cyc(); cyc();
    s0_tvalid[0] = 1'b0;
    checks++; if (pkt_cnt0[0] !== 16'h0001) begin errors++; $display("FAIL wrap_one: got %h exp 0001", pkt_cnt0[0]); end
    s0_tvalid[0] = 1'b1; s0_tlast[0] = 1'b0; s0_tdata[0] = 64'hF1;
    cyc();
    checks++; if (grant[0] !== 2'b01) begin errors++; $display("FAIL mr_grant: got %b exp 01", grant[0]); end
    cyc();
    s0_tdata[0] = 64'hF2;
    user_reset = 1'b1;
    cyc();
    checks++; if (grant[0] !== 2'b00) begin errors++; $display("FAIL mr_grant_clr: got %b exp 00", grant[0]); end
    checks++; if (s0_tready[0] !== 1'b0 || s1_tready[0] !== 1'b0 || m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL mr_outputs: got r0=%b r1=%b v=%b exp 0/0/0", s0_tready[0], s1_tready[0], m_tvalid[0]); end
    checks++; if (pkt_cnt0[0] !== 16'd0 || pkt_cnt1[0] !== 16'd0) begin errors++; $display("FAIL mr_cnt: got %0d/%0d exp 0/0", pkt_cnt0[0], pkt_cnt1[0]); end
    user_reset = 1'b0;
    s0_tvalid[0] = 1'b0;
    s0_tdata[0] = 64'h10; s0_tlast[0] = 1'b1; s0_tvalid[0] = 1'b1;
    s1_tdata[0] = 64'h20; s1_tlast[0] = 1'b1; s1_tvalid[0] = 1'b1;
    cyc();
    checks++; if (grant[0] !== 2'b01) begin errors++; $display("FAIL mr_ptr: got %b exp 01", grant[0]); end
    s0_tvalid[0] = 1'b0; s1_tvalid[0] = 1'b0;
  endtask

  initial begin
    user_reset = 1'b1;
    idle_inputs();
    test_reset();
    test_first_tie();
    test_round_robin();
    test_fixed_prio();
    test_buf_threshold();
    test_tready_toggle();
    test_single_beat();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
